// File: rtl/gf180mcu_fd_sc_mcu7t5v0__des4_1.sv
// -----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__des4_1
//
// Four-bit serial-in / parallel-out deserializer with a one-word holding
// register, a valid/ready handoff and an all-zero flag.
//
// Serial bits arrive on D whenever E is high. The first bit lands in Q1 and
// the fourth bit lands in Q4. When the fourth bit arrives, the completed word
// is offered in Q1..Q4 and VLD goes high. The consumer takes the word by
// raising RDY while VLD is high.
//
// If a word completes while the held word is still unconsumed, the new word
// is dropped and the sticky OVF flag is set. OVF clears only on RST.
//
// ZN is the NOR of the held word. It depends only on Q, not on VLD.
//
// Ports
//   CLK     in   clock; all state changes on the rising edge
//   RST     in   synchronous, active-high reset
//   D       in   serial data bit
//   E       in   shift enable; D is sampled only when E=1
//   RDY     in   consumer accepts the held word this cycle
//   Q1..Q4  out  held word; Q1 is the first serial bit, Q4 the last
//   VLD     out  held word is valid and not yet consumed
//   OVF     out  sticky overrun flag
//   ZN      out  1 when the held word is all zero
// -----------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu7t5v0__des4_1 (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  input  logic E,
  input  logic RDY,
  output logic Q1,
  output logic Q2,
  output logic Q3,
  output logic Q4,
  output logic VLD,
  output logic OVF,
  output logic ZN
);

  logic [1:0] cnt_q, cnt_d;
  logic [2:0] p_q,   p_d;
  logic [3:0] q_q,   q_d;
  logic       vld_q, vld_d;
  logic       ovf_q, ovf_d;
  logic       done;

  // The word completes on the fourth enabled bit. That bit goes straight into
  // the output word and is never stored in the partial register.
  assign done = E && (cnt_q == 2'd3);

  always_comb begin
    cnt_d = cnt_q;
    p_d   = p_q;
    q_d   = q_q;
    vld_d = vld_q;
    ovf_d = ovf_q;

    if (E) begin
      if (cnt_q != 2'd3) begin
        p_d[cnt_q] = D;
      end
      // The 2-bit counter wraps from 3 back to 0 on its own.
      cnt_d = cnt_q + 2'd1;
    end

    if (done) begin
      // A consume on the same edge frees the slot for the new word.
      if (!vld_q || RDY) begin
        q_d   = {D, p_q};
        vld_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (vld_q && RDY) begin
      // After the handoff, Q keeps the last value; only VLD drops.
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= 2'd0;
      p_q   <= 3'd0;
      q_q   <= 4'd0;
      vld_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      p_q   <= p_d;
      q_q   <= q_d;
      vld_q <= vld_d;
      ovf_q <= ovf_d;
    end
  end

  assign Q1  = q_q[0];
  assign Q2  = q_q[1];
  assign Q3  = q_q[2];
  assign Q4  = q_q[3];
  assign VLD = vld_q;
  assign OVF = ovf_q;
  assign ZN  = ~(q_q[0] | q_q[1] | q_q[2] | q_q[3]);

`ifndef FUNCTIONAL
  specify
    (CLK => Q1)  = (1.0, 1.0);
    (CLK => Q2)  = (1.0, 1.0);
    (CLK => Q3)  = (1.0, 1.0);
    (CLK => Q4)  = (1.0, 1.0);
    (CLK => VLD) = (1.0, 1.0);
    (CLK => OVF) = (1.0, 1.0);
    (CLK => ZN)  = (1.0, 1.0);
    $setuphold(posedge CLK, D,   0, 0);
    $setuphold(posedge CLK, E,   0, 0);
    $setuphold(posedge CLK, RDY, 0, 0);
    $setuphold(posedge CLK, RST, 0, 0);
  endspecify
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__des4_1.sv
module tb_gf180mcu_fd_sc_mcu7t5v0__des4_1;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic D   = 1'b0;
  logic E   = 1'b0;
  logic RDY = 1'b0;
  logic Q1, Q2, Q3, Q4, VLD, OVF, ZN;

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0] exp_q[$];

  gf180mcu_fd_sc_mcu7t5v0__des4_1 dut (
    .CLK (CLK),
    .RST (RST),
    .D   (D),
    .E   (E),
    .RDY (RDY),
    .Q1  (Q1),
    .Q2  (Q2),
    .Q3  (Q3),
    .Q4  (Q4),
    .VLD (VLD),
    .OVF (OVF),
    .ZN  (ZN)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [3:0] word();
    return {Q4, Q3, Q2, Q1};
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge. Outputs are sampled 1 ns after the
  // next rising edge.
  task automatic step(input logic d, input logic e, input logic rdy, input logic rst);
    @(negedge CLK);
    D = d; E = e; RDY = rdy; RST = rst;
    @(posedge CLK);
    #1;
  endtask

  task automatic sb_check(input string tag);
    logic [3:0] w;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s observed=%b expected=<scoreboard empty>", tag, word());
    end else begin
      n_chk--;
      w = exp_q.pop_front();
      chk(tag, word(), w);
    end
  endtask

  initial begin
    // Reset with random values on the other inputs
    step(1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    step(1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    chk("rst_q",   word(),     4'b0000);
    chk("rst_vld", {3'b0,VLD}, 4'd0);
    chk("rst_ovf", {3'b0,OVF}, 4'd0);
    chk("rst_zn",  {3'b0,ZN},  4'd1);

    // Single word 1,0,1,1 with RDY low
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("single_vld_early", {3'b0,VLD}, 4'd0);
    exp_q.push_back(4'b1101);
    step(1, 1, 0, 0);
    sb_check("single_word");
    chk("single_vld", {3'b0,VLD}, 4'd1);
    chk("single_zn",  {3'b0,ZN},  4'd0);
    step(0, 0, 1, 0);
    chk("single_consume_vld", {3'b0,VLD}, 4'd0);
    chk("single_q_held",      word(),     4'b1101);

    // Gapped enable: four zero bits with E low for 3 cycles between them
    for (int b = 0; b < 4; b++) begin
      if (b == 3) exp_q.push_back(4'b0000);
      step(0, 1, 0, 0);
      if (b < 3) begin
        chk("gap_vld_early", {3'b0,VLD}, 4'd0);
        for (int g = 0; g < 3; g++) step(1, 0, 0, 0);
        chk("gap_vld_idle", {3'b0,VLD}, 4'd0);
      end
    end
    sb_check("gap_word");
    chk("gap_vld", {3'b0,VLD}, 4'd1);
    chk("gap_zn",  {3'b0,ZN},  4'd1);
    step(0, 0, 1, 0);
    chk("gap_consume_vld", {3'b0,VLD}, 4'd0);

    // Overrun: 1,1,0,0 is held; 0,1,0,1 arrives while RDY stays low
    exp_q.push_back(4'b0011);
    step(1, 1, 0, 0); step(1, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0);
    sb_check("ovr_first");
    chk("ovr_ovf_before", {3'b0,OVF}, 4'd0);
    step(0, 1, 0, 0); step(1, 1, 0, 0); step(0, 1, 0, 0); step(1, 1, 0, 0);
    chk("ovr_q_kept", word(),     4'b0011);
    chk("ovr_vld",    {3'b0,VLD}, 4'd1);
    chk("ovr_ovf",    {3'b0,OVF}, 4'd1);
    step(0, 0, 1, 0);
    chk("ovr_consume_vld", {3'b0,VLD}, 4'd0);
    chk("ovr_ovf_sticky",  {3'b0,OVF}, 4'd1);
    step(0, 0, 0, 0); step(0, 0, 1, 0);
    chk("ovr_ovf_sticky2", {3'b0,OVF}, 4'd1);
    step(0, 0, 0, 1);
    chk("ovr_ovf_rst", {3'b0,OVF}, 4'd0);

    // Back-to-back words with RDY held high: 0001 then 1000 (Q4..Q1)
    exp_q.push_back(4'b0001);
    step(1, 1, 1, 0); step(0, 1, 1, 0); step(0, 1, 1, 0); step(0, 1, 1, 0);
    sb_check("b2b_word1");
    chk("b2b_vld1", {3'b0,VLD}, 4'd1);
    exp_q.push_back(4'b1000);
    step(0, 1, 1, 0);
    chk("b2b_q_held", word(), 4'b0001);
    step(0, 1, 1, 0); step(0, 1, 1, 0); step(1, 1, 1, 0);
    sb_check("b2b_word2");
    chk("b2b_vld2", {3'b0,VLD}, 4'd1);
    chk("b2b_ovf",  {3'b0,OVF}, 4'd0);
    step(0, 0, 1, 0);

    // Reset mid-word: two bits are lost, then 1,1,1,1 arrives
    step(0, 1, 0, 0); step(0, 1, 0, 0);
    step(1, 1, 1, 1);
    chk("mid_rst_q",   word(),     4'b0000);
    chk("mid_rst_vld", {3'b0,VLD}, 4'd0);
    step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);
    chk("mid_vld_early", {3'b0,VLD}, 4'd0);
    exp_q.push_back(4'b1111);
    step(1, 1, 0, 0);
    sb_check("mid_word");
    chk("mid_vld", {3'b0,VLD}, 4'd1);

    // Reset while a word is held drops it
    step(0, 0, 0, 1);
    chk("rst_held_vld", {3'b0,VLD}, 4'd0);
    chk("rst_held_q",   word(),     4'b0000);
    chk("rst_held_zn",  {3'b0,ZN},  4'd1);

    chk("sb_empty", 4'(exp_q.size()), 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
